// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and stop.
module uart_tx_fifo_reader #(
    parameter int unsigned NB_UARTTX_DATA      = 8,
    parameter int unsigned SB_UARTTX_TICK      = 16,
    parameter int unsigned N_UARTTX_OVERSAMPLE = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_uarttx_TICK,
    input  logic                      i_uarttx_FIFOEMPTY,
    input  logic [NB_UARTTX_DATA-1:0] i_uarttx_FIFODATA,
    output logic                      o_uarttx_FIFOREAD,
    output logic                      o_uarttx_TX,
    output logic                      o_uarttx_BUSY,
    output logic                      o_uarttx_DONE
);

    localparam int unsigned TickMax = (N_UARTTX_OVERSAMPLE > SB_UARTTX_TICK) ?
                                      N_UARTTX_OVERSAMPLE : SB_UARTTX_TICK;
    localparam int unsigned CntW    = (TickMax > 1) ? $clog2(TickMax) : 1;
    localparam int unsigned IdxW    = (NB_UARTTX_DATA > 1) ? $clog2(NB_UARTTX_DATA) : 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(N_UARTTX_OVERSAMPLE - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(SB_UARTTX_TICK - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NB_UARTTX_DATA - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                    state_q;
    logic [CntW-1:0]           tick_cnt_q;
    logic [IdxW-1:0]           bit_idx_q;
    logic [NB_UARTTX_DATA-1:0] shift_q;
    logic [NB_UARTTX_DATA-1:0] shift_nxt;
    logic                      tx_q;
    logic                      busy_q;
    logic                      done_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    // The DONE cycle is the one idle gap between frames, so no pop is taken in it.
    assign o_uarttx_FIFOREAD = !i_reset && (state_q == StIdle) && !i_uarttx_FIFOEMPTY && !done_q;

    assign shift_nxt     = shift_q >> 1;
    assign o_uarttx_TX   = tx_q;
    assign o_uarttx_BUSY = busy_q;
    assign o_uarttx_DONE = done_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (o_uarttx_FIFOREAD) begin
                        shift_q    <= i_uarttx_FIFODATA;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^i_uarttx_FIFODATA;
`endif
                        tick_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (i_uarttx_TICK) begin
                        if (tick_cnt_q == BitLast) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            tx_q       <= shift_q[0];
                            state_q    <= StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + CntW'(1);
                        end
                    end
                end
                StData: begin
                    if (i_uarttx_TICK) begin
                        if (tick_cnt_q == BitLast) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_nxt;
                            if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                                tx_q    <= parity_q;
                                state_q <= StParity;
`else
                                tx_q    <= 1'b1;
                                state_q <= StStop;
`endif
                            end else begin
                                bit_idx_q <= bit_idx_q + IdxW'(1);
                                tx_q      <= shift_nxt[0];
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + CntW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (i_uarttx_TICK) begin
                        if (tick_cnt_q == BitLast) begin
                            tick_cnt_q <= '0;
                            tx_q       <= 1'b1;
                            state_q    <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + CntW'(1);
                        end
                    end
                end
`endif
                StStop: begin
                    if (i_uarttx_TICK) begin
                        if (tick_cnt_q == StopLast) begin
                            tick_cnt_q <= '0;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader with a queue-based FIFO model.
// Follows UART_TX_PARITY_EN to expect the extra parity bit.
module tb_uart_tx_fifo_reader;

`ifdef UART_TX_PARITY_EN
    localparam int Segs  = 11;
    localparam bit ParEn = 1'b1;
`else
    localparam int Segs  = 10;
    localparam bit ParEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         fails  = 0;

    uart_tx_fifo_reader dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_uarttx_TICK      (i_tick),
        .i_uarttx_FIFOEMPTY (fifo_empty),
        .i_uarttx_FIFODATA  (fifo_data),
        .o_uarttx_FIFOREAD  (fifo_read),
        .o_uarttx_TX        (tx),
        .o_uarttx_BUSY      (busy),
        .o_uarttx_DONE      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Head word is junk whenever the FIFO is empty, and changes every cycle.
    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic step(input logic t, output logic rd);
        i_tick = t;
        #1;
        rd = fifo_read;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int seg);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        if (ParEn && seg == 9) return ^b;
        return 1'b1;
    endfunction

    // Pop happens at step n=0; DONE is visible after step 16*p*Segs.
    task automatic frame(input logic [7:0] b, input int p, input string tag);
        int   last;
        int   e_tx;
        int   e_busy;
        int   e_done;
        int   e_rd;
        logic rd;
        last = 16 * p * Segs;
        e_tx = 0; e_busy = 0; e_done = 0; e_rd = 0;
        for (int n = 0; n <= last; n++) begin
            step((n % p) == 0, rd);
            if (rd !== (n == 0)) e_rd++;
            if (n < last) begin
                if (tx !== exp_tx(b, n / (16 * p))) e_tx++;
                if (busy !== 1'b1) e_busy++;
                if (done !== 1'b0) e_done++;
            end else begin
                if (tx !== 1'b1) e_tx++;
                if (busy !== 1'b0) e_busy++;
                if (done !== 1'b1) e_done++;
            end
        end
        chk({tag, " tx_errs"}, e_tx, 0);
        chk({tag, " busy_errs"}, e_busy, 0);
        chk({tag, " done_errs"}, e_done, 0);
        chk({tag, " fiforead_errs"}, e_rd, 0);
    endtask

    task automatic gap(input string tag);
        logic rd;
        step(1'b1, rd);
        chk({tag, " gap_fiforead"}, rd, 0);
        chk({tag, " gap_tx"}, tx, 1);
        chk({tag, " gap_done"}, done, 0);
    endtask

    initial begin
        logic rd;
        int   e_tx;
        int   e_busy;
        int   e_rd;
        int   e_done;

        i_reset = 1'b1;
        i_tick  = 1'b0;
        drive_fifo();
        step(1'b1, rd);
        step(1'b1, rd);
        chk("reset fiforead", rd, 0);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        // Empty FIFO with constant ticks must stay idle.
        i_reset = 1'b0;
        e_tx = 0; e_busy = 0; e_rd = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, rd);
            if (rd !== 1'b0) e_rd++;
            if (tx !== 1'b1) e_tx++;
            if (busy !== 1'b0) e_busy++;
        end
        chk("idle fiforead_count", e_rd, 0);
        chk("idle tx_errs", e_tx, 0);
        chk("idle busy_errs", e_busy, 0);

        fifo_q.push_back(8'hA5);
        drive_fifo();
        frame(8'hA5, 1, "a5");
        gap("a5");

        // Back-to-back: second pop is one cycle after DONE.
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        drive_fifo();
        frame(8'h01, 1, "b2b_01");
        gap("b2b_01");
        frame(8'hFF, 1, "b2b_ff");
        gap("b2b_ff");

        fifo_q.push_back(8'h3C);
        drive_fifo();
        frame(8'h3C, 4, "slow_3c");
        gap("slow_3c");

        fifo_q.push_back(8'h07);
        fifo_q.push_back(8'h03);
        drive_fifo();
        frame(8'h07, 1, "par_07");
        gap("par_07");
        frame(8'h03, 1, "par_03");
        gap("par_03");

        // Abort 0x55 in the middle of data bit 3 (segment 4).
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h81);
        drive_fifo();
        e_tx = 0; e_done = 0;
        for (int n = 0; n <= 16 * 4 + 8; n++) begin
            step(1'b1, rd);
            if (tx !== exp_tx(8'h55, n / 16)) e_tx++;
            if (done !== 1'b0) e_done++;
        end
        chk("abort pre_tx_errs", e_tx, 0);
        chk("abort pre_done_errs", e_done, 0);
        chk("abort bit3_tx", tx, 0);
        i_reset = 1'b1;
        step(1'b1, rd);
        chk("abort rst_fiforead", rd, 0);
        chk("abort rst_tx", tx, 1);
        chk("abort rst_busy", busy, 0);
        chk("abort rst_done", done, 0);
        step(1'b1, rd);
        chk("abort pending_pop_blocked", rd, 0);
        chk("abort rst2_done", done, 0);
        i_reset = 1'b0;
        frame(8'h81, 1, "post_rst_81");
        gap("post_rst_81");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 Parameter NB_UARTTX_DATA, default 8: data bits per frame and FIFO word width.
REQ-002 Parameter SB_UARTTX_TICK, default 16: oversampling ticks per stop bit (16 = 1 stop bit).
REQ-003 Parameter N_UARTTX_OVERSAMPLE, default 16: oversampling ticks per start, data and parity bit.
REQ-004 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_uarttx_TICK  input  1  one-cycle baud oversampling strobe from the baud generator.
REQ-007 i_uarttx_FIFOEMPTY  input  1  empty flag from the upstream FIFO.
REQ-008 i_uarttx_FIFODATA  input  NB_UARTTX_DATA  FIFO head word, combinationally valid whenever the FIFO is not empty.
REQ-009 o_uarttx_FIFOREAD  output  1  one-cycle pop strobe to the FIFO.
REQ-010 o_uarttx_TX  output  1  serial line, idle high.
REQ-011 o_uarttx_BUSY  output  1  high in every state except IDLE.
REQ-012 o_uarttx_DONE  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when enabled (REQ-026).
REQ-014 In IDLE with i_uarttx_FIFOEMPTY=0, in the same cycle: latch i_uarttx_FIFODATA into the shift register, assert o_uarttx_FIFOREAD for exactly that cycle, clear the tick counter, and go to START.
REQ-015 o_uarttx_FIFOREAD SHALL never assert outside IDLE, and never while i_uarttx_FIFOEMPTY=1.
REQ-016 The tick counter SHALL advance only on cycles with i_uarttx_TICK=1; cycles without a tick SHALL leave all state unchanged.
REQ-017 START: o_uarttx_TX=0. On the tick with count=N_UARTTX_OVERSAMPLE-1: go to DATA, count=0, bit index=0.
REQ-018 DATA: o_uarttx_TX = shift register bit 0 (LSB first). On the tick with count=N_UARTTX_OVERSAMPLE-1: shift right by one and increment bit index. If bit index=NB_UARTTX_DATA-1, go to STOP (or PARITY) instead.
REQ-019 STOP: o_uarttx_TX=1. On the tick with count=SB_UARTTX_TICK-1: pulse o_uarttx_DONE for one cycle and go to IDLE.
REQ-020 Back-to-back: if the FIFO is non-empty on the cycle after DONE, the next pop SHALL occur in that cycle (one IDLE cycle between frames).
REQ-021 In IDLE, o_uarttx_TX SHALL be 1.
REQ-022 The tick counter SHALL be ceil(log2(max(N_UARTTX_OVERSAMPLE, SB_UARTTX_TICK))) bits wide. The bit index SHALL be ceil(log2(NB_UARTTX_DATA)) bits wide. Neither SHALL wrap mid-bit.
REQ-023 Changes on i_uarttx_FIFODATA after the pop SHALL NOT affect the frame in flight.

Reset
REQ-024 With i_reset=1 at a clock edge, the next state SHALL be: FSM=IDLE, counters=0, shift register=0, o_uarttx_TX=1, o_uarttx_FIFOREAD=0, o_uarttx_BUSY=0, o_uarttx_DONE=0.
REQ-025 Reset SHALL take priority over all other inputs, including i_uarttx_TICK and a pending pop. A frame interrupted by reset SHALL be abandoned: its byte is lost, and no DONE is issued for it.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: state PARITY SHALL follow DATA and drive the even-parity bit (XOR of the latched byte) for N_UARTTX_OVERSAMPLE ticks, then go to STOP. The frame is then 1+NB+1+1 bits.
REQ-027 Macro UART_TX_PARITY_EN undefined: no PARITY state and no parity logic exist; DATA goes directly to STOP.

Verification
REQ-028 Reset, FIFO empty, tick every cycle for 500 cycles -> TX=1, BUSY=0, FIFOREAD never asserted.
REQ-029 FIFO holds 0xA5, tick every cycle -> one FIFOREAD pulse. TX=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles. DONE pulses on cycle 161 after the pop.
REQ-030 FIFO holds 0x01 and 0xFF back-to-back -> second FIFOREAD exactly 1 cycle after the first DONE. Both frames are correct on TX.
REQ-031 Tick every 4th cycle, byte 0x3C -> each bit lasts 64 clocks, and the state is frozen on non-tick cycles.
REQ-032 Reset asserted in DATA bit 3 of 0x55 -> next cycle TX=1 and BUSY=0, with no DONE. After release with the FIFO non-empty, a fresh pop and a full frame follow.
REQ-033 With UART_TX_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bits 1 and 0 respectively, each between bit 7 and stop. DONE arrives 16 ticks later than in the non-parity build.
